// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the counter width used by the VGA controller.
package vga_timing_pkg;

    localparam int CNT_W = 11;

    localparam int H_ACTIVE_DEF   = 640;
    localparam int H_FP_END_DEF   = 648;
    localparam int H_SYNC_END_DEF = 744;
    localparam int H_TOTAL_DEF    = 800;

    localparam int V_ACTIVE_DEF   = 480;
    localparam int V_FP_END_DEF   = 490;
    localparam int V_SYNC_END_DEF = 492;
    localparam int V_TOTAL_DEF    = 525;

    localparam logic SYNC_ACTIVE_DEF = 1'b0;

endpackage

// File: rtl/vga_timing_counter.sv
// One VGA timing axis: wrapping counter with enable, registered sync decode and
// a look-ahead active-region flag so the parent can register blank without skew.
module vga_timing_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE      = H_ACTIVE_DEF,
    parameter int   FP_END      = H_FP_END_DEF,
    parameter int   SYNC_END    = H_SYNC_END_DEF,
    parameter int   TOTAL       = H_TOTAL_DEF,
    parameter logic SYNC_ACTIVE = SYNC_ACTIVE_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             active_next
);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_LIM  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] FP_LIM   = CNT_W'(FP_END);
    localparam logic [CNT_W-1:0] SYNC_LIM = CNT_W'(SYNC_END);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             sync_reg;
    logic             sync_next;

    always_comb begin
        count_next = count_reg;
        if (en) begin
            count_next = (count_reg == LAST) ? '0 : count_reg + ONE;
        end
    end

    // Decode from the next count so sync lands in the same cycle as its count.
    always_comb begin
        sync_next   = ~SYNC_ACTIVE;
        active_next = (count_next < ACT_LIM);
        if ((count_next >= FP_LIM) && (count_next < SYNC_LIM)) begin
            sync_next = SYNC_ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            sync_reg  <= ~SYNC_ACTIVE;
        end else begin
            count_reg <= count_next;
            sync_reg  <= sync_next;
        end
    end

    assign count = count_reg;
    assign sync  = sync_reg;

endmodule

// File: rtl/vga_controller_640_60.sv
// VGA 640x480@60 timing generator: counters, HS/VS and blank, all registered and aligned.
// Optional frame_start pulse output is built when VGA_FRAME_START_EN is defined.
module vga_controller_640_60
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = H_ACTIVE_DEF,
    parameter int   H_FP_END    = H_FP_END_DEF,
    parameter int   H_SYNC_END  = H_SYNC_END_DEF,
    parameter int   H_TOTAL     = H_TOTAL_DEF,
    parameter int   V_ACTIVE    = V_ACTIVE_DEF,
    parameter int   V_FP_END    = V_FP_END_DEF,
    parameter int   V_SYNC_END  = V_SYNC_END_DEF,
    parameter int   V_TOTAL     = V_TOTAL_DEF,
    parameter logic SYNC_ACTIVE = SYNC_ACTIVE_DEF
)
(
    input  logic             pixel_clk,
    input  logic             rst,
`ifdef VGA_FRAME_START_EN
    output logic             frame_start,
`endif
    output logic             HS,
    output logic             VS,
    output logic [CNT_W-1:0] hcounter,
    output logic [CNT_W-1:0] vcounter,
    output logic             blank
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);

    logic             h_last;
    logic             h_active_next;
    logic             v_active_next;
    logic             blank_reg;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;

    assign h_last = (h_count == H_LAST);

    vga_timing_counter #(
        .ACTIVE      (H_ACTIVE),
        .FP_END      (H_FP_END),
        .SYNC_END    (H_SYNC_END),
        .TOTAL       (H_TOTAL),
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_h_counter (
        .clk         (pixel_clk),
        .rst         (rst),
        .en          (1'b1),
        .count       (h_count),
        .sync        (HS),
        .active_next (h_active_next)
    );

    // Lines advance only on the edge where the column counter wraps.
    vga_timing_counter #(
        .ACTIVE      (V_ACTIVE),
        .FP_END      (V_FP_END),
        .SYNC_END    (V_SYNC_END),
        .TOTAL       (V_TOTAL),
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_v_counter (
        .clk         (pixel_clk),
        .rst         (rst),
        .en          (h_last),
        .count       (v_count),
        .sync        (VS),
        .active_next (v_active_next)
    );

    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            blank_reg <= 1'b0;
        end else begin
            blank_reg <= ~(h_active_next & v_active_next);
        end
    end

    assign hcounter = h_count;
    assign vcounter = v_count;
    assign blank    = blank_reg;

`ifdef VGA_FRAME_START_EN
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic frame_start_reg;

    // The counters step to (0,0) on the edge after the last pixel of the last line.
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= h_last && (v_count == V_LAST);
        end
    end

    assign frame_start = frame_start_reg;
`endif

endmodule

// File: tb/tb_vga_controller_640_60.sv
// Directed bench: default 640x480 instance for line-level timing and reset,
// plus a shrunken-timing instance to cover whole frames in few cycles.
module tb_vga_controller_640_60;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        hs_d, vs_d, blank_d;
    logic [10:0] hc_d, vc_d;
    logic        hs_s, vs_s, blank_s;
    logic [10:0] hc_s, vc_s;
`ifdef VGA_FRAME_START_EN
    logic        fs_d, fs_s;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_controller_640_60 dut (
        .pixel_clk   (clk),
        .rst         (rst),
`ifdef VGA_FRAME_START_EN
        .frame_start (fs_d),
`endif
        .HS          (hs_d),
        .VS          (vs_d),
        .hcounter    (hc_d),
        .vcounter    (vc_d),
        .blank       (blank_d)
    );

    // Small frame: 20 clocks/line, 12 lines/frame.
    vga_controller_640_60 #(
        .H_ACTIVE    (10),
        .H_FP_END    (12),
        .H_SYNC_END  (15),
        .H_TOTAL     (20),
        .V_ACTIVE    (6),
        .V_FP_END    (8),
        .V_SYNC_END  (10),
        .V_TOTAL     (12),
        .SYNC_ACTIVE (1'b0)
    ) dut_s (
        .pixel_clk   (clk),
        .rst         (rst),
`ifdef VGA_FRAME_START_EN
        .frame_start (fs_s),
`endif
        .HS          (hs_s),
        .VS          (vs_s),
        .hcounter    (hc_s),
        .vcounter    (vc_s),
        .blank       (blank_s)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic next_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int   eh;
        int   ev;
        int   hs_low;
        int   hs_pulses;
        int   vs_pulses;
        int   v_max;
        int   fs_cnt;
        logic hs_prev;
        logic vs_prev;

        // Reset held across a rising edge.
        @(negedge clk);
        check_value("rst_h", hc_d, 0);
        check_value("rst_v", vc_d, 0);
        check_value("rst_hs", hs_d, 1);
        check_value("rst_vs", vs_d, 1);
        check_value("rst_blank", blank_d, 0);
        check_value("rst_s_h", hc_s, 0);
        check_value("rst_s_blank", blank_s, 0);
`ifdef VGA_FRAME_START_EN
        check_value("rst_fs", fs_d, 0);
`endif

        // Release and walk one full line of the default timing.
        rst = 1'b1;
        hs_low = 0;
        for (int k = 1; k <= 800; k++) begin
            next_edges(1);
            eh = k % 800;
            ev = (k == 800) ? 1 : 0;
            check_value("line_h", hc_d, eh);
            check_value("line_v", vc_d, ev);
            check_value("line_hs", hs_d, (eh >= 648 && eh < 744) ? 0 : 1);
            check_value("line_vs", vs_d, 1);
            check_value("line_blank", blank_d, (eh >= 640) ? 1 : 0);
`ifdef VGA_FRAME_START_EN
            check_value("line_fs", fs_d, 0);
`endif
            if (k < 800 && hs_d == 1'b0) hs_low++;
            if (k == 1)   check_value("first_edge_h", hc_d, 1);
            if (k == 639) check_value("blank_639", blank_d, 0);
            if (k == 640) check_value("blank_640", blank_d, 1);
            if (k == 647) check_value("hs_647", hs_d, 1);
            if (k == 648) check_value("hs_648", hs_d, 0);
            if (k == 743) check_value("hs_743", hs_d, 0);
            if (k == 744) check_value("hs_744", hs_d, 1);
            if (k == 799) check_value("wrap_pre_v", vc_d, 0);
            if (k == 800) check_value("wrap_v", vc_d, 1);
        end
        check_value("hs_low_clocks", hs_low, 96);

        // Move to (300,1), then assert reset between edges.
        next_edges(300);
        check_value("pre_rst_h", hc_d, 300);
        check_value("pre_rst_v", vc_d, 1);
        check_value("pre_rst_blank", blank_d, 0);
        #2;
        rst = 1'b0;
        #1;
        check_value("async_h", hc_d, 0);
        check_value("async_v", vc_d, 0);
        check_value("async_hs", hs_d, 1);
        check_value("async_vs", vs_d, 1);
        check_value("async_blank", blank_d, 0);
        check_value("async_s_h", hc_s, 0);
        @(negedge clk);
        check_value("held_h", hc_d, 0);
        check_value("held_v", vc_d, 0);
        rst = 1'b1;

        // Two small frames, with the default instance running alongside.
        hs_prev   = 1'b1;
        vs_prev   = 1'b1;
        hs_pulses = 0;
        vs_pulses = 0;
        v_max     = 0;
        fs_cnt    = 0;
        for (int k = 1; k <= 480; k++) begin
            next_edges(1);
            eh = k % 20;
            ev = (k / 20) % 12;
            if (k == 1) begin
                check_value("resume_h", hc_d, 1);
                check_value("resume_v", vc_d, 0);
            end
            check_value("frm_h", hc_s, eh);
            check_value("frm_v", vc_s, ev);
            check_value("frm_hs", hs_s, (eh >= 12 && eh < 15) ? 0 : 1);
            check_value("frm_vs", vs_s, (ev >= 8 && ev < 10) ? 0 : 1);
            check_value("frm_blank", blank_s, (eh >= 10 || ev >= 6) ? 1 : 0);
            check_value("big_h", hc_d, k);
            if (k == 109) check_value("blank_9_5", blank_s, 0);
            if (k == 120) check_value("blank_0_6", blank_s, 1);
            if (k == 239) check_value("last_pix_v", vc_s, 11);
            if (k == 240) check_value("frame_wrap_v", vc_s, 0);
            if (k <= 240) begin
                if (hs_prev && !hs_s) hs_pulses++;
                if (vs_prev && !vs_s) vs_pulses++;
                if (int'(vc_s) > v_max) v_max = int'(vc_s);
            end
            hs_prev = hs_s;
            vs_prev = vs_s;
`ifdef VGA_FRAME_START_EN
            check_value("frm_fs", fs_s, (eh == 0 && ev == 0) ? 1 : 0);
            if (fs_s) fs_cnt++;
`endif
        end
        check_value("hs_pulses", hs_pulses, 12);
        check_value("vs_pulses", vs_pulses, 1);
        check_value("v_max", v_max, 11);
        check_value("big_v", vc_d, 0);
`ifdef VGA_FRAME_START_EN
        check_value("fs_count", fs_cnt, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_controller_640_60.md
VGA_CONTROLLER_640_60 -- requirements
Module: vga_controller_640_60

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have parameter H_FP_END, default 648, meaning the first hsync-pulse column.
REQ-003 The block SHALL have parameter H_SYNC_END, default 744, meaning the first column after the hsync pulse.
REQ-004 The block SHALL have parameter H_TOTAL, default 800, meaning clocks per line.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-006 The block SHALL have parameter V_FP_END, default 490, meaning the first vsync-pulse line.
REQ-007 The block SHALL have parameter V_SYNC_END, default 492, meaning the first line after the vsync pulse.
REQ-008 The block SHALL have parameter V_TOTAL, default 525, meaning lines per frame.
REQ-009 The block SHALL have parameter SYNC_ACTIVE, default 1'b0, meaning the HS/VS level during the pulse.
REQ-010 The block SHALL have port pixel_clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-011 The block SHALL have port rst, input, width 1: asynchronous, active-low reset.
REQ-012 The block SHALL have port HS, output, width 1: horizontal sync.
REQ-013 The block SHALL have port VS, output, width 1: vertical sync.
REQ-014 The block SHALL have port hcounter, output, width 11: current column, 0..H_TOTAL-1.
REQ-015 The block SHALL have port vcounter, output, width 11: current line, 0..V_TOTAL-1.
REQ-016 The block SHALL have port blank, output, width 1: high outside the visible area.

Function
REQ-017 hcounter SHALL increment by 1 each clock and wrap from H_TOTAL-1 (799) to 0.
REQ-018 vcounter SHALL increment by 1 only in the clock where hcounter wraps, and SHALL wrap from V_TOTAL-1 (524) to 0 on that same edge.
REQ-019 HS, VS and blank SHALL be registered outputs that describe the hcounter/vcounter values presented in the same cycle (zero relative skew, no combinational output paths).
REQ-020 HS SHALL equal SYNC_ACTIVE exactly when H_FP_END <= hcounter < H_SYNC_END, and ~SYNC_ACTIVE otherwise.
REQ-021 VS SHALL equal SYNC_ACTIVE exactly when V_FP_END <= vcounter < V_SYNC_END, and ~SYNC_ACTIVE otherwise.
REQ-022 blank SHALL be 1 when hcounter >= H_ACTIVE or vcounter >= V_ACTIVE, and 0 otherwise.
REQ-023 Counter comparisons SHALL be unsigned 11-bit; counters SHALL never present a value >= their TOTAL.

Reset
REQ-024 While rst=0, the block SHALL force hcounter=0, vcounter=0, HS=~SYNC_ACTIVE, VS=~SYNC_ACTIVE and blank=0 immediately, independent of pixel_clk.
REQ-025 The first rising edge after rst deasserts SHALL present hcounter=1, vcounter=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame, and counting SHALL restart from (0,0).

Configuration
REQ-027 When macro VGA_FRAME_START_EN is defined, the block SHALL add an output frame_start (width 1), registered, that is high for exactly one cycle when hcounter=0 and vcounter=0, and 0 during reset.
REQ-028 When VGA_FRAME_START_EN is not defined, the frame_start port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-029 A shared package vga_timing_pkg SHALL hold the 640x480@60 timing constants (all REQ-001..REQ-009 defaults) and the counter width constant (11).
REQ-030 One sub-module, vga_timing_counter, SHALL be instantiated twice (horizontal and vertical): wrapping counter with enable, plus sync and active-region decode.

Verification
REQ-031 Release reset, then run 800 clocks -> hcounter goes 0..799, then 0; vcounter goes 0 to 1 on the wrap edge.
REQ-032 Run 1 full frame (420000 clocks) -> vcounter reaches 524, then both counters return to 0; exactly 525 HS pulses and 1 VS pulse occur.
REQ-033 At line 0 -> HS=0 for hcounter 648..743 (96 clocks), and HS=1 at 647 and at 744.
REQ-034 Check blank -> 0 at (639,479), 1 at (640,0), 1 at (0,480); VS=0 for vcounter 490..491 only.
REQ-035 Assert rst=0 at (300,200) asynchronously -> outputs are reset before the next edge; after release, counting resumes from (1,0).
REQ-036 With VGA_FRAME_START_EN defined -> frame_start pulses once per 420000 clocks, in the cycle where the counters read (0,0).
